fetch_ctrl: RTL and testbench

Sequencing controller for the fetch path: PC mux, PC register, instruction memory and IF/ID pipeline register.
- Every cycle it decides the PC mux select and the PC register enable.
- It also drives the IF/ID register enable and flush, and the bubble insert into ID/EX.
- Inputs are hazard, branch-resolution, prediction and memory-ready signals from later stages.
- It owns boot sequencing out of reset and halt handling.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_boot_counter.sv | 25 ++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch sequencing controller.
package fetch_pkg;

  localparam int PCSEL_W = 3;

  localparam logic [PCSEL_W-1:0] PCSEL_RESET  = 3'b111;
  localparam logic [PCSEL_W-1:0] PCSEL_PC4    = 3'b001;
  localparam logic [PCSEL_W-1:0] PCSEL_BRANCH = 3'b010;
  localparam logic [PCSEL_W-1:0] PCSEL_PRED   = 3'b100;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT_MEM,
    ST_HALT
  } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Hazard/status inputs and fetch-path control outputs of the fetch controller.
interface fetch_ctrl_if #(
  parameter int PCSEL_W = 3
) ();

  logic               load_use;
  logic               mispredict;
  logic               predict_taken;
  logic               imem_ready;
  logic               halt_req;
  logic [PCSEL_W-1:0] pc_sel;
  logic               pc_en;
  logic               ifid_en;
  logic               ifid_flush;
  logic               idex_bubble;
  logic               fetch_valid;
  logic               busy;

  // The controller drives the fetch-path controls.
  modport master (
    input  load_use, mispredict, predict_taken, imem_ready, halt_req,
    output pc_sel, pc_en, ifid_en, ifid_flush, idex_bubble, fetch_valid, busy
  );

  // The pipeline supplies hazards and consumes the controls.
  modport slave (
    output load_use, mispredict, predict_taken, imem_ready, halt_req,
    input  pc_sel, pc_en, ifid_en, ifid_flush, idex_bubble, fetch_valid, busy
  );

endinterface

// File: rtl/fetch_boot_counter.sv
// Saturating boot-cycle counter; done is high during the last boot cycle.
module fetch_boot_counter #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  assign done = (count >= W'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: boot hold, hazard priorities, memory wait and halt.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int PCSEL_W     = 3
) (
  input  logic    clk,
  input  logic    rst,
  fetch_ctrl_if.master bus
);

  state_t             state;
  state_t             state_next;
  logic               boot_done;
  logic [PCSEL_W-1:0] pc_sel_c;

  fetch_boot_counter #(
    .LIMIT(BOOT_CYCLES)
  ) u_boot_counter (
    .clk  (clk),
    .clear(rst),
    .inc  (state == ST_BOOT),
    .done (boot_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_sel_c        = PCSEL_W'(PCSEL_PC4);
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.busy        = 1'b1;

    if (rst) begin
      state_next      = ST_BOOT;
      pc_sel_c        = PCSEL_W'(PCSEL_RESET);
      bus.pc_en       = 1'b1;
      bus.ifid_en     = 1'b1;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else begin
      case (state)
        ST_BOOT: begin
          pc_sel_c       = PCSEL_W'(PCSEL_RESET);
          bus.pc_en      = 1'b1;
          bus.ifid_en    = 1'b1;
          bus.ifid_flush = 1'b1;
          if (boot_done) state_next = ST_RUN;
        end
        ST_RUN, ST_WAIT_MEM: begin
          // Redirect beats everything; halt beats the stall/wait conditions.
          if (bus.mispredict) begin
            state_next      = ST_RUN;
            pc_sel_c        = PCSEL_W'(PCSEL_BRANCH);
            bus.pc_en       = 1'b1;
            bus.ifid_en     = 1'b1;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
          end else if (bus.halt_req) begin
            state_next     = ST_HALT;
            bus.pc_en      = 1'b1;
            bus.ifid_en    = 1'b1;
            bus.ifid_flush = 1'b1;
          end else if ((state == ST_RUN) && bus.load_use) begin
            bus.idex_bubble = 1'b1;
          end else if (!bus.imem_ready) begin
            state_next     = ST_WAIT_MEM;
            bus.ifid_en    = 1'b1;
            bus.ifid_flush = 1'b1;
          end else begin
            state_next      = ST_RUN;
            pc_sel_c        = bus.predict_taken ? PCSEL_W'(PCSEL_PRED) : PCSEL_W'(PCSEL_PC4);
            bus.pc_en       = 1'b1;
            bus.ifid_en     = 1'b1;
            bus.fetch_valid = 1'b1;
          end
        end
        ST_HALT: begin
          bus.idex_bubble = 1'b1;
          bus.busy        = 1'b0;
        end
        default: begin
          state_next = ST_BOOT;
        end
      endcase
    end
  end

  assign bus.pc_sel = pc_sel_c;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, then random stimulus against a reference model.
module tb_fetch_ctrl;

  localparam int          BOOT_CYCLES = 2;
  localparam logic [31:0] BR_TARGET   = 32'h0000_0020;
  localparam logic [31:0] PRED_TARGET = 32'h0000_0040;

  // Packed as {pc_sel[2:0], pc_en, ifid_en, ifid_flush, idex_bubble, fetch_valid, busy}.
  localparam logic [8:0] E_RST  = 9'b111_1_1_1_1_0_1;
  localparam logic [8:0] E_BOOT = 9'b111_1_1_1_0_0_1;
  localparam logic [8:0] E_RUN  = 9'b001_1_1_0_0_1_1;
  localparam logic [8:0] E_PRED = 9'b100_1_1_0_0_1_1;
  localparam logic [8:0] E_LU   = 9'b001_0_0_0_1_0_1;
  localparam logic [8:0] E_WAIT = 9'b001_0_1_1_0_0_1;
  localparam logic [8:0] E_MP   = 9'b010_1_1_1_1_0_1;
  localparam logic [8:0] E_HREQ = 9'b001_1_1_1_0_0_1;
  localparam logic [8:0] E_HALT = 9'b001_0_0_0_1_0_0;

  typedef struct {
    logic r, lu, mp, pt, rdy, hr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [8:0]  e;
    bit          chk;
    logic [31:0] pc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] tb_pc;
  int          total;
  int          bad;

  int          boot_seen;
  bit          halted;
  bit          waiting;
  logic [31:0] mpc;

  vec_t vecs[$];

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .PCSEL_W    (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in PC register and mux so redirects and stalls show up as PC values.
  always @(posedge clk) begin
    if (bus.pc_en) begin
      case (bus.pc_sel)
        3'b111:  tb_pc <= 32'h0;
        3'b001:  tb_pc <= tb_pc + 32'd4;
        3'b010:  tb_pc <= BR_TARGET;
        3'b100:  tb_pc <= PRED_TARGET;
        default: tb_pc <= 32'hDEAD_BEEF;
      endcase
    end
  end

  function automatic vec_t mk(input logic r, lu, mp, pt, rdy, hr,
                              input logic [8:0] e, input bit chk, input logic [31:0] pc);
    vec_t v;
    v.s.r = r; v.s.lu = lu; v.s.mp = mp; v.s.pt = pt; v.s.rdy = rdy; v.s.hr = hr;
    v.e = e; v.chk = chk; v.pc = pc;
    return v;
  endfunction

  function automatic logic [8:0] care(input logic [8:0] e);
    logic [8:0] m;
    m = 9'h1FF;
    if (!e[5]) m[8:6] = 3'b000;
    if (!e[0]) m[3] = 1'b0;
    return m;
  endfunction

  // Expected outputs from the behavioural rules, given the abstract model state.
  function automatic logic [8:0] model_eval(input stim_t s);
    if (s.r)                             return E_RST;
    else if (halted)                     return E_HALT;
    else if (boot_seen < BOOT_CYCLES)    return E_BOOT;
    else if (s.mp)                       return E_MP;
    else if (s.hr)                       return E_HREQ;
    else if (!waiting && s.lu)           return E_LU;
    else if (!s.rdy)                     return E_WAIT;
    else if (s.pt)                       return E_PRED;
    else                                 return E_RUN;
  endfunction

  task automatic model_step(input stim_t s);
    if (s.r) begin
      boot_seen = 0; halted = 1'b0; waiting = 1'b0; mpc = 32'h0;
    end else if (halted) begin
      mpc = mpc;
    end else if (boot_seen < BOOT_CYCLES) begin
      boot_seen = boot_seen + 1; mpc = 32'h0;
    end else if (s.mp) begin
      waiting = 1'b0; mpc = BR_TARGET;
    end else if (s.hr) begin
      halted = 1'b1; mpc = mpc + 32'd4;
    end else if (!waiting && s.lu) begin
      mpc = mpc;
    end else if (!s.rdy) begin
      waiting = 1'b1;
    end else begin
      waiting = 1'b0;
      mpc = s.pt ? PRED_TARGET : mpc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst               = s.r;
    bus.load_use      = s.lu;
    bus.mispredict    = s.mp;
    bus.predict_taken = s.pt;
    bus.imem_ready    = s.rdy;
    bus.halt_req      = s.hr;
    #4;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] e);
    logic [8:0] act;
    logic [8:0] m;
    act = {bus.pc_sel, bus.pc_en, bus.ifid_en, bus.ifid_flush,
           bus.idex_bubble, bus.fetch_valid, bus.busy};
    m = care(e);
    total++;
    if ((act & m) !== (e & m)) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b (care=%b)", name, act, e, m);
    end
  endtask

  task automatic checkPc(input string name, input logic [31:0] want);
    total++;
    if (tb_pc !== want) begin
      bad++;
      $display("[TB] FAIL %s: pc got=%h want=%h", name, tb_pc, want);
    end
  endtask

  task automatic advance(input stim_t s);
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  initial begin
    stim_t s;
    total = 0; bad = 0;
    boot_seen = 0; halted = 1'b0; waiting = 1'b0; mpc = 32'h0;
    rst = 1'b1;
    bus.load_use = 1'b0; bus.mispredict = 1'b0; bus.predict_taken = 1'b0;
    bus.imem_ready = 1'b1; bus.halt_req = 1'b0;

    //            r  lu mp pt rdy hr  expect  chk pc
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, E_RST,  0, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, E_RST,  1, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, E_RST,  1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, E_BOOT, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_BOOT, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h04));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h08));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h0C));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, E_LU,   1, 32'h10));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h10));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, E_MP,   1, 32'h14));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, E_LU,   1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, E_WAIT, 1, 32'h20));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, E_WAIT, 1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, E_WAIT, 1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, E_PRED, 1, 32'h24));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h40));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, E_WAIT, 1, 32'h44));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, E_MP,   1, 32'h44));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, E_LU,   1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, E_WAIT, 1, 32'h20));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, E_RST,  1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_BOOT, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_BOOT, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_RUN,  1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, E_HREQ, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, E_HALT, 1, 32'h08));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, E_HALT, 1, 32'h08));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, E_HALT, 1, 32'h08));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, E_HALT, 1, 32'h08));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, E_RST,  1, 32'h08));

    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      if (vecs[i].chk) checkPc($sformatf("vec%0d_pc", i), vecs[i].pc);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
      advance(vecs[i].s);
    end

    for (int i = 0; i < 400; i++) begin
      s.r   = ($urandom_range(0, 39) == 0);
      s.lu  = ($urandom_range(0, 4) == 0);
      s.mp  = ($urandom_range(0, 7) == 0);
      s.pt  = ($urandom_range(0, 3) == 0);
      s.rdy = ($urandom_range(0, 3) != 0);
      s.hr  = ($urandom_range(0, 49) == 0);
      applyStimulus(s);
      checkPc($sformatf("rnd%0d_pc", i), mpc);
      checkOutput($sformatf("rnd%0d", i), model_eval(s));
      advance(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
